sign_narrow: RTL and testbench

//  Inverse of sign extension on the store/write-back path: narrows 32-bit words to 16 bits
//  (truncate, signed saturate, unsigned saturate) and flags values that do not fit.

---
 rtl/sign_narrow_pkg.sv | 26 ++
 rtl/sign_narrow_if.sv | 26 ++
 rtl/sign_narrow_core.sv | 57 +++++
 rtl/sign_narrow.sv | 105 ++++++++++
 tb/tb_sign_narrow.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sign_narrow_pkg.sv
// Shared constants for the 32->16 narrowing path: mode encodings and saturation limits.
// No logic here; helpers are constant functions usable in parameter contexts.
// Consumers import kgp_narrow_pkg::*.
package kgp_narrow_pkg;

    // Narrowing mode encodings; 2'b11 is treated like truncation.
    localparam logic [1:0] MODE_TRUNC = 2'b00;
    localparam logic [1:0] MODE_SSAT  = 2'b01;
    localparam logic [1:0] MODE_USAT  = 2'b10;

    // Saturation limits for the default 16-bit output.
    localparam logic [15:0] SAT16_SMAX = 16'h7FFF;
    localparam logic [15:0] SAT16_SMIN = 16'h8000;
    localparam logic [15:0] SAT16_UMAX = 16'hFFFF;

    // Largest positive two's-complement value of a w-bit field.
    function automatic logic [63:0] sat_smax(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative two's-complement value of a w-bit field (bit pattern only).
    function automatic logic [63:0] sat_smin(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/sign_narrow_if.sv
// Stream bundle for the narrowing unit: input word channel plus narrowed output channel.
// master = producer/consumer environment, slave = the narrowing unit.
// Handshake is plain valid/ready on both channels.
interface sign_narrow_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_ovf;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/sign_narrow_core.sv
// Combinational narrowing of one word: truncate, signed saturate or unsigned saturate.
// Latency 0 (pure combinational).
// No backpressure; the caller registers the result.
module narrow_sat_core
    import kgp_narrow_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]  i_data,
    input  logic [1:0]       i_mode,
    output logic [OUT_W-1:0] o_data,
    output logic             o_ovf
);

    localparam logic [OUT_W-1:0] SMAX = OUT_W'(sat_smax(OUT_W));
    localparam logic [OUT_W-1:0] SMIN = OUT_W'(sat_smin(OUT_W));

    // Bits that must all equal the output sign bit for a signed fit.
    logic [IN_W-OUT_W:0]   w_sign_hi;
    // Bits that must be zero for an unsigned fit.
    logic [IN_W-OUT_W-1:0] w_unsigned_hi;
    logic                  w_fits_s;
    logic                  w_fits_u;
    logic [OUT_W-1:0]      w_trunc;

    assign w_sign_hi     = i_data[IN_W-1:OUT_W-1];
    assign w_unsigned_hi = i_data[IN_W-1:OUT_W];
    assign w_fits_s      = (w_sign_hi == '0) || (w_sign_hi == '1);
    assign w_fits_u      = (w_unsigned_hi == '0);
    assign w_trunc       = i_data[OUT_W-1:0];

    // Select result and overflow by mode; truncation overflow is the same
    // "does not sign-extend back" test as signed saturation.
    always_comb begin
        o_data = w_trunc;
        o_ovf  = !w_fits_s;
        case (i_mode)
            MODE_SSAT: begin
                if (!w_fits_s) begin
                    o_data = i_data[IN_W-1] ? SMIN : SMAX;
                end
            end
            MODE_USAT: begin
                o_ovf = !w_fits_u;
                if (!w_fits_u) begin
                    o_data = '1;
                end
            end
            default: begin
                o_data = w_trunc;
                o_ovf  = !w_fits_s;
            end
        endcase
    end

endmodule

// File: rtl/sign_narrow.sv
// Narrows IN_W-bit words to OUT_W bits with overflow flag, plus sticky flag and saturating count.
// Latency 1 cycle, throughput 1/cycle while out_ready is high.
// 2-entry (main + skid) buffer; in_ready is registered and drops only when skid fills.
module sign_narrow
    import kgp_narrow_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    sign_narrow_if.slave     io_bus,
    input  logic             i_clr_sticky,
    output logic             o_sticky_ovf,
    output logic [CNT_W-1:0] o_ovf_count
);

    logic [OUT_W-1:0] w_nar_data;
    logic             w_nar_ovf;
    logic             w_accept;
    logic             w_handoff;

    logic             r_main_vld;
    logic [OUT_W-1:0] r_main_dat;
    logic             r_main_ovf;
    logic             r_skid_vld;
    logic [OUT_W-1:0] r_skid_dat;
    logic             r_skid_ovf;
    logic             r_sticky;
    logic [CNT_W-1:0] r_cnt;

    narrow_sat_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .i_data (io_bus.in_data),
        .i_mode (io_bus.in_mode),
        .o_data (w_nar_data),
        .o_ovf  (w_nar_ovf)
    );

    // in_ready comes straight from the skid flop, so it is registered.
    assign w_accept  = io_bus.in_valid && !r_skid_vld;
    assign w_handoff = r_main_vld && io_bus.out_ready;

    assign io_bus.in_ready  = !r_skid_vld;
    assign io_bus.out_valid = r_main_vld;
    assign io_bus.out_data  = r_main_dat;
    assign io_bus.out_ovf   = r_main_ovf;
    assign o_sticky_ovf     = r_sticky;
    assign o_ovf_count      = r_cnt;

    // Main/skid buffer: skid only fills when main is held; on handoff skid drains into main.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_main_vld <= 1'b0;
            r_main_dat <= '0;
            r_main_ovf <= 1'b0;
            r_skid_vld <= 1'b0;
            r_skid_dat <= '0;
            r_skid_ovf <= 1'b0;
        end else if (w_handoff) begin
            if (r_skid_vld) begin
                r_main_dat <= r_skid_dat;
                r_main_ovf <= r_skid_ovf;
                r_skid_vld <= 1'b0;
            end else if (w_accept) begin
                r_main_dat <= w_nar_data;
                r_main_ovf <= w_nar_ovf;
            end else begin
                r_main_vld <= 1'b0;
            end
        end else if (w_accept) begin
            if (!r_main_vld) begin
                r_main_vld <= 1'b1;
                r_main_dat <= w_nar_data;
                r_main_ovf <= w_nar_ovf;
            end else begin
                r_skid_vld <= 1'b1;
                r_skid_dat <= w_nar_data;
                r_skid_ovf <= w_nar_ovf;
            end
        end
    end

    // Overflow statistics: an overflowing handoff beats a simultaneous clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end else if (w_handoff && r_main_ovf) begin
            r_sticky <= 1'b1;
            if (i_clr_sticky) begin
                r_cnt <= CNT_W'(1);
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else if (i_clr_sticky) begin
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end
    end

endmodule

// File: tb/tb_sign_narrow.sv
// Self-checking bench for sign_narrow: vector table, hand-written corner sequences,
// and a randomized scoreboard against an arithmetic reference model.
module tb_sign_narrow;

    logic       clk;
    logic       rst;
    logic       clr_sticky;
    logic       sticky_ovf;
    logic [7:0] ovf_count;

    int checks   = 0;
    int failures = 0;

    sign_narrow_if #(.IN_W(32), .OUT_W(16)) bus ();

    sign_narrow #(.IN_W(32), .OUT_W(16), .CNT_W(8)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .io_bus       (bus.slave),
        .i_clr_sticky (clr_sticky),
        .o_sticky_ovf (sticky_ovf),
        .o_ovf_count  (ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] din;
        logic [1:0]  mode;
        logic [15:0] exp_dat;
        logic        exp_ovf;
    } vec_t;

    typedef struct {
        logic [31:0] din;
        logic [1:0]  mode;
        logic [15:0] dat;
        logic        ovf;
    } exp_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: the mode rules as numeric range tests on the input value.
    task automatic ref_narrow(input logic [31:0] d, input logic [1:0] m,
                              output logic [15:0] o, output logic ovf);
        longint sv;
        longint uv;
        logic [15:0] lo;
        sv = longint'($signed(d));
        uv = longint'(d);
        lo = d[15:0];
        if (m == 2'b01) begin
            if (sv > 32767) begin o = 16'h7FFF; ovf = 1'b1; end
            else if (sv < -32768) begin o = 16'h8000; ovf = 1'b1; end
            else begin o = lo; ovf = 1'b0; end
        end else if (m == 2'b10) begin
            if (uv > 65535) begin o = 16'hFFFF; ovf = 1'b1; end
            else begin o = lo; ovf = 1'b0; end
        end else begin
            o = lo;
            ovf = (longint'($signed(lo)) != sv);
        end
    endtask

    function automatic logic [31:0] rand_word();
        int sel;
        sel = $urandom_range(0, 3);
        case (sel)
            0: return $urandom();
            1: return 32'($urandom_range(0, 80000)) - 32'd40000;
            2: return 32'($urandom_range(60000, 70000));
            default: return 32'($urandom_range(32700, 32800)) * (($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'd1);
        endcase
    endfunction

    vec_t vecs[12];
    exp_t q[$];

    initial begin
        int ovf_handoffs;
        int done;
        int cyc;
        logic [15:0] rd;
        logic ro;
        exp_t e;

        vecs[0]  = '{32'h0001_2345, 2'b01, 16'h7FFF, 1'b1};
        vecs[1]  = '{32'hFFFF_8000, 2'b01, 16'h8000, 1'b0};
        vecs[2]  = '{32'hFFFE_0000, 2'b01, 16'h8000, 1'b1};
        vecs[3]  = '{32'h0000_936E, 2'b00, 16'h936E, 1'b1};
        vecs[4]  = '{32'h0000_936E, 2'b10, 16'h936E, 1'b0};
        vecs[5]  = '{32'h0001_2D15, 2'b10, 16'hFFFF, 1'b1};
        vecs[6]  = '{32'h0001_2345, 2'b11, 16'h2345, 1'b1};
        vecs[7]  = '{32'h0000_7FFF, 2'b01, 16'h7FFF, 1'b0};
        vecs[8]  = '{32'h0000_8000, 2'b01, 16'h7FFF, 1'b1};
        vecs[9]  = '{32'hFFFF_FFFF, 2'b10, 16'hFFFF, 1'b1};
        vecs[10] = '{32'hFFFF_8000, 2'b00, 16'h8000, 1'b0};
        vecs[11] = '{32'h0000_FFFF, 2'b10, 16'hFFFF, 1'b0};

        // Reset held two cycles with a word offered.
        rst = 1'b1;
        clr_sticky = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 32'h0001_2345;
        bus.in_mode = 2'b01;
        bus.out_ready = 1'b0;
        step();
        step();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
        check("rst_ovf_count", 32'(ovf_count), 32'd0);
        check("rst_sticky", 32'(sticky_ovf), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        step();
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);

        // Vector table, one word per cycle, consumer always ready.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = vecs[i].din;
            bus.in_mode = vecs[i].mode;
            step();
            check($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("vec%0d_data", i), 32'(bus.out_data), 32'(vecs[i].exp_dat));
            check($sformatf("vec%0d_ovf", i), 32'(bus.out_ovf), 32'(vecs[i].exp_ovf));
        end
        bus.in_valid = 1'b0;
        step();
        check("empty_out_valid", 32'(bus.out_valid), 32'd0);
        check("empty_holds_data", 32'(bus.out_data), 32'h0000_FFFF);

        // Backpressure: three words offered while stalled, only two fit.
        bus.out_ready = 1'b0;
        bus.in_mode = 2'b00;
        bus.in_valid = 1'b1;
        bus.in_data = 32'h0000_1111;
        step();
        check("bp_ready_after_1", 32'(bus.in_ready), 32'd1);
        bus.in_data = 32'h0000_2222;
        step();
        check("bp_ready_after_2", 32'(bus.in_ready), 32'd0);
        bus.in_data = 32'h0000_3333;
        step();
        check("bp_ready_held", 32'(bus.in_ready), 32'd0);
        check("bp_stall_valid", 32'(bus.out_valid), 32'd1);
        check("bp_stall_data", 32'(bus.out_data), 32'h1111);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check("bp_second_valid", 32'(bus.out_valid), 32'd1);
        check("bp_second_data", 32'(bus.out_data), 32'h2222);
        check("bp_ready_restored", 32'(bus.in_ready), 32'd1);
        step();
        check("bp_drained", 32'(bus.out_valid), 32'd0);

        // Stats saturation with 300 overflowing handoffs.
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        check("clr_count", 32'(ovf_count), 32'd0);
        check("clr_sticky", 32'(sticky_ovf), 32'd0);
        bus.in_mode = 2'b01;
        bus.in_data = 32'h0001_2345;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 300; i++) step();
        bus.in_valid = 1'b0;
        step();
        step();
        check("sat_count", 32'(ovf_count), 32'd255);
        check("sat_sticky", 32'(sticky_ovf), 32'd1);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        check("clr_vs_ovf_count", 32'(ovf_count), 32'd1);
        check("clr_vs_ovf_sticky", 32'(sticky_ovf), 32'd1);
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        check("clr_alone_count", 32'(ovf_count), 32'd0);
        check("clr_alone_sticky", 32'(sticky_ovf), 32'd0);

        // Reset with both buffers full.
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        step();
        step();
        bus.in_valid = 1'b0;
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_out_data", 32'(bus.out_data), 32'd0);

        // Randomized traffic against the reference model.
        ovf_handoffs = 0;
        done = 0;
        cyc = 0;
        while (done < 10000 && cyc < 60000) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.in_data = rand_word();
            bus.in_mode = 2'($urandom_range(0, 3));
            check("rnd_in_ready", 32'(bus.in_ready), (q.size() < 2) ? 32'd1 : 32'd0);
            check("rnd_out_valid", 32'(bus.out_valid), (q.size() > 0) ? 32'd1 : 32'd0);
            if (bus.out_valid && bus.out_ready && q.size() > 0) begin
                e = q.pop_front();
                check("rnd_data", 32'(bus.out_data), 32'(e.dat));
                check("rnd_ovf", 32'(bus.out_ovf), 32'(e.ovf));
                if (e.mode == 2'b01 && !bus.out_ovf) begin
                    check("rnd_roundtrip", {{16{bus.out_data[15]}}, bus.out_data}, e.din);
                end
                if (e.ovf) ovf_handoffs++;
                done++;
            end
            if (bus.in_valid && bus.in_ready) begin
                ref_narrow(bus.in_data, bus.in_mode, rd, ro);
                q.push_back('{bus.in_data, bus.in_mode, rd, ro});
            end
            step();
            cyc++;
        end
        check("rnd_completed", 32'(done), 32'd10000);
        check("rnd_count", 32'(ovf_count), (ovf_handoffs > 255) ? 32'd255 : 32'(ovf_handoffs));
        check("rnd_sticky", 32'(sticky_ovf), (ovf_handoffs > 0) ? 32'd1 : 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
